// File: rtl/zx_pager_pkg.sv
// ---------------------------------------------------------------------------
// zx_pager_pkg
// Shared constants and helpers for the ZX memory pager:
//   - I/O port decode constants (7FFD, 1FFD, E3)
//   - DivMMC automap entry points, the 1FF8 exit window and the 3Dxx trap page
//   - automap FSM state encoding, read-data source encoding
//   - DivMMC SDRAM base address and the +3 all-RAM bank table
// ---------------------------------------------------------------------------
package zx_pager_pkg;

    // Port decode constants
    localparam logic [7:0]  PORT_E3      = 8'hE3;
    localparam logic [3:0]  PORT_1FFD_HI = 4'h1;   // a[15:12] of port 1FFD

    // DivMMC automap addresses
    localparam int          N_ENTRY   = 6;
    localparam logic [15:0] ENTRY_PTS [N_ENTRY] = '{
        16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562
    };
    localparam logic [15:0] EXIT_MASK = 16'hFFF8;
    localparam logic [15:0] EXIT_BASE = 16'h1FF8;
    localparam logic [7:0]  TRAP_PAGE = 8'h3D;     // a[15:8] of the TR-DOS style trap

    // DivMMC RAM lives above the main RAM banks in SDRAM
    localparam logic [23:0] DIV_BASE  = 24'h040000;

    typedef enum logic [1:0] {
        AM_IDLE   = 2'd0,
        AM_ARM    = 2'd1,
        AM_ON     = 2'd2,
        AM_DISARM = 2'd3
    } am_state_t;

    typedef enum logic [1:0] {
        SRC_SDRAM = 2'd0,
        SRC_ROM   = 2'd1,
        SRC_ESX   = 2'd2
    } src_t;

    // +3 all-RAM configurations, indexed [cfg][slot]
    localparam logic [2:0] SPECIAL_BANK [4][4] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3},
        '{3'd4, 3'd5, 3'd6, 3'd7},
        '{3'd4, 3'd5, 3'd6, 3'd3},
        '{3'd4, 3'd7, 3'd6, 3'd3}
    };

    function automatic logic is_entry(input logic [15:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (addr == ENTRY_PTS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_exit(input logic [15:0] addr);
        return (addr & EXIT_MASK) == EXIT_BASE;
    endfunction

    function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] slot);
        return SPECIAL_BANK[cfg][slot];
    endfunction

endpackage

// File: rtl/divmmc_automap.sv
// ---------------------------------------------------------------------------
// divmmc_automap
// DivMMC automap state machine plus the E3 control register.
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_ce                CPU clock enable
//   i_divEn             0 holds the FSM in IDLE and blocks E3 writes
//   i_mreq/i_iorq/i_wr/i_m1   Z80 strobes, active-low
//   i_a                 CPU address
//   i_dHi               CPU data bits [7:6] (forcemap, mapram)
//   i_dPage             CPU data bits [PW-1:0] (page select)
//   i_romSel            current ROM select, the 3Dxx trap needs ROM 3
//   o_automap           FSM is in a mapped state (or a 3Dxx trap fetch)
//   o_forcemap, o_mapram, o_divPage   E3 register fields
// ---------------------------------------------------------------------------
module divmmc_automap
    import zx_pager_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ce,
    input  logic          i_divEn,
    input  logic          i_mreq,
    input  logic          i_iorq,
    input  logic          i_wr,
    input  logic          i_m1,
    input  logic [15:0]   i_a,
    input  logic [1:0]    i_dHi,
    input  logic [PW-1:0] i_dPage,
    input  logic [1:0]    i_romSel,
    output logic          o_automap,
    output logic          o_forcemap,
    output logic          o_mapram,
    output logic [PW-1:0] o_divPage
);

    am_state_t     r_state;
    logic          r_fetchSeen;
    logic          r_forcemap;
    logic          r_mapram;
    logic [PW-1:0] r_divPage;

    logic w_fetch;
    logic w_firstFetch;
    logic w_trap;
    logic w_e3Wr;

    assign w_fetch      = !i_mreq && !i_m1;
    // Only the first ce cycle of an opcode fetch moves the FSM.
    assign w_firstFetch = i_ce && w_fetch && !r_fetchSeen;
    // The trap must map the very fetch that hits it, so it is also fed
    // combinationally into o_automap below.
    assign w_trap       = i_divEn && w_fetch && (i_a[15:8] == TRAP_PAGE) && (i_romSel == 2'b11);
    assign w_e3Wr       = i_ce && i_divEn && !i_iorq && !i_wr && (i_a[7:0] == PORT_E3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= AM_IDLE;
            r_fetchSeen <= 1'b0;
            r_forcemap  <= 1'b0;
            r_mapram    <= 1'b0;
            r_divPage   <= '0;
        end else begin
            if (i_ce) begin
                if (w_fetch)   r_fetchSeen <= 1'b1;
                else if (i_m1) r_fetchSeen <= 1'b0;
            end

            if (!i_divEn) begin
                r_state <= AM_IDLE;
            end else if (w_firstFetch) begin
                if (w_trap) begin
                    r_state <= AM_ON;
                end else if (is_entry(i_a)) begin
                    if (r_state == AM_IDLE || r_state == AM_DISARM) r_state <= AM_ARM;
                end else if (is_exit(i_a)) begin
                    if (r_state == AM_ON || r_state == AM_ARM) r_state <= AM_DISARM;
                end
            end else if (i_ce && i_m1) begin
                // Entry/exit take effect once the triggering fetch has completed.
                if (r_state == AM_ARM)         r_state <= AM_ON;
                else if (r_state == AM_DISARM) r_state <= AM_IDLE;
            end

            if (w_e3Wr) begin
                r_forcemap <= i_dHi[1];
                r_mapram   <= r_mapram | i_dHi[0];   // only reset clears mapram
                r_divPage  <= i_dPage;
            end
        end
    end

    assign o_automap  = (r_state == AM_ON) || (r_state == AM_DISARM) || w_trap;
    assign o_forcemap = r_forcemap;
    assign o_mapram   = r_mapram;
    assign o_divPage  = r_divPage;

endmodule

// File: rtl/zx_pager.sv
// ---------------------------------------------------------------------------
// zx_pager
// ZX Spectrum 128K/+3 memory pager with DivMMC mapping and an SDRAM
// request/acknowledge handshake.
//   clock, reset          system clock, asynchronous active-high reset
//   ce                    CPU clock enable
//   divEn                 DivMMC enable
//   mreq/iorq/rd/wr/m1/rfsh  Z80 strobes, active-low
//   a, d                  CPU address and data out
//   sdrReq/sdrWe/sdrA     SDRAM request level, write flag, byte address
//   sdrAck                one-cycle completion pulse from SDRAM
//   wait_n                CPU wait, low while a request is outstanding
//   src                   read-data source (0 sdram, 1 rom, 2 esxdos)
//   romSel                {romHi, romLo}
//   vidBank               0 = bank 5, 1 = bank 7
//   mapped                DivMMC memory is paged in
// ---------------------------------------------------------------------------
module zx_pager
    import zx_pager_pkg::*;
#(
    parameter int RAMBANKS = 8,
    parameter int DIVPAGES = 16,
    parameter int AW       = 24,
    parameter int PLUS3    = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          divEn,
    input  logic          mreq,
    input  logic          iorq,
    input  logic          rd,
    input  logic          wr,
    input  logic          m1,
    input  logic          rfsh,
    input  logic [15:0]   a,
    input  logic [7:0]    d,
    output logic          sdrReq,
    output logic          sdrWe,
    output logic [AW-1:0] sdrA,
    input  logic          sdrAck,
    output logic          wait_n,
    output logic [1:0]    src,
    output logic [1:0]    romSel,
    output logic          vidBank,
    output logic          mapped
);

    localparam int BW = $clog2(RAMBANKS);
    localparam int PW = $clog2(DIVPAGES);

    // Paging registers
    logic [BW-1:0] r_ramBank;
    logic          r_vidBank;
    logic          r_romLo;
    logic          r_romHi;
    logic          r_lock;
    logic          r_special;
    logic [1:0]    r_cfg;

    // Handshake registers
    logic          r_sdrReq;
    logic          r_sdrWe;
    logic [AW-1:0] r_sdrA;
    logic          r_memSeen;

    // DivMMC
    logic          w_automap;
    logic          w_forcemap;
    logic          w_mapram;
    logic [PW-1:0] w_divPage;
    logic          w_mapped;

    // Decode
    src_t          w_src;
    logic          w_isDiv;
    logic          w_ro;
    logic [BW-1:0] w_bank;
    logic [PW-1:0] w_page;
    logic [AW-1:0] w_addr;
    logic [BW-1:0] w_newBank;

    logic w_ioWr;
    logic w_is7ffd;
    logic w_is1ffd;
    logic w_memStrobe;
    logic w_start;

    divmmc_automap #(
        .PW(PW)
    ) u_automap (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_ce       (ce),
        .i_divEn    (divEn),
        .i_mreq     (mreq),
        .i_iorq     (iorq),
        .i_wr       (wr),
        .i_m1       (m1),
        .i_a        (a),
        .i_dHi      (d[7:6]),
        .i_dPage    (d[PW-1:0]),
        .i_romSel   ({r_romHi, r_romLo}),
        .o_automap  (w_automap),
        .o_forcemap (w_forcemap),
        .o_mapram   (w_mapram),
        .o_divPage  (w_divPage)
    );

    assign w_mapped = w_forcemap | w_automap;

    // Pentagon-style extension: bank bit 3 from d[6], bit 4 from d[7].
    if (BW > 3) begin : g_xbank
        assign w_newBank = {d[6 +: BW-3], d[2:0]};
    end else begin : g_nobank
        assign w_newBank = d[2:0];
    end

    assign w_ioWr   = ce && !iorq && !wr;
    // 7FFD is only partially decoded, so a 1FFD write also lands in 7FFD.
    assign w_is7ffd = !a[15] && !a[1];
    assign w_is1ffd = (PLUS3 != 0) && (a[15:12] == PORT_1FFD_HI) && !a[1];

    always_comb begin
        w_src   = SRC_SDRAM;
        w_isDiv = 1'b0;
        w_ro    = 1'b0;
        w_bank  = '0;
        w_page  = '0;
        if (a[15:14] == 2'b00 && w_mapped) begin
            if (!a[13]) begin
                if (w_mapram) begin
                    w_isDiv = 1'b1;
                    w_page  = PW'(3);
                    w_ro    = 1'b1;
                end else begin
                    w_src   = SRC_ESX;
                    w_ro    = 1'b1;
                end
            end else begin
                w_isDiv = 1'b1;
                w_page  = w_divPage;
                w_ro    = w_mapram && (w_divPage == PW'(3));
            end
        end else if (r_special) begin
            w_bank = BW'(special_bank(r_cfg, a[15:14]));
        end else begin
            case (a[15:14])
                2'b00: begin
                    w_src = SRC_ROM;
                    w_ro  = 1'b1;
                end
                2'b01:   w_bank = BW'(5);
                2'b10:   w_bank = BW'(2);
                default: w_bank = r_ramBank;
            endcase
        end
    end

    assign w_addr = w_isDiv ? (AW'(DIV_BASE) + AW'({w_page, a[12:0]}))
                            : AW'({w_bank, a[13:0]});

    // One request per bus access: r_memSeen blocks re-triggering until mreq rises.
    assign w_memStrobe = !mreq && rfsh && (!rd || !wr);
    assign w_start     = ce && w_memStrobe && !r_memSeen && !r_sdrReq &&
                         (w_src == SRC_SDRAM) && !(!wr && w_ro);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ramBank <= '0;
            r_vidBank <= 1'b0;
            r_romLo   <= 1'b0;
            r_romHi   <= 1'b0;
            r_lock    <= 1'b0;
            r_special <= 1'b0;
            r_cfg     <= 2'b00;
            r_sdrReq  <= 1'b0;
            r_sdrWe   <= 1'b0;
            r_sdrA    <= '0;
            r_memSeen <= 1'b0;
        end else begin
            if (w_ioWr && !r_lock) begin
                if (w_is7ffd) begin
                    r_ramBank <= w_newBank;
                    r_vidBank <= d[3];
                    r_romLo   <= d[4];
                    r_lock    <= d[5];
                end
                if (w_is1ffd) begin
                    r_special <= d[0];
                    r_cfg     <= d[2:1];
                    r_romHi   <= d[2];
                end
            end

            if (ce) begin
                if (w_memStrobe) r_memSeen <= 1'b1;
                else if (mreq)   r_memSeen <= 1'b0;
            end

            if (w_start) begin
                r_sdrReq <= 1'b1;
                r_sdrWe  <= !wr;
                r_sdrA   <= w_addr;
            end else if (r_sdrReq && sdrAck) begin
                r_sdrReq <= 1'b0;
            end
        end
    end

    assign sdrReq  = r_sdrReq;
    assign sdrWe   = r_sdrWe;
    assign sdrA    = r_sdrA;
    assign wait_n  = !r_sdrReq;
    assign src     = w_src;
    assign romSel  = {r_romHi, r_romLo};
    assign vidBank = r_vidBank;
    assign mapped  = w_mapped;

endmodule

// File: tb/tb_zx_pager.sv
module tb_zx_pager;

    logic        clock = 1'b0;
    logic        reset, ce, divEn, mreq, iorq, rd, wr, m1, rfsh, sdrAck;
    logic [15:0] a;
    logic [7:0]  d;
    logic        sdrReq, sdrWe, wait_n, vidBank, mapped;
    logic [23:0] sdrA;
    logic [1:0]  src, romSel;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        isWr;
        logic        isRfsh;
        logic        expReq;
        logic [23:0] expA;
        logic [1:0]  expSrc;
    } vec_t;

    vec_t tbl [8];

    always #5 clock = ~clock;

    zx_pager dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .divEn   (divEn),
        .mreq    (mreq),
        .iorq    (iorq),
        .rd      (rd),
        .wr      (wr),
        .m1      (m1),
        .rfsh    (rfsh),
        .a       (a),
        .d       (d),
        .sdrReq  (sdrReq),
        .sdrWe   (sdrWe),
        .sdrA    (sdrA),
        .sdrAck  (sdrAck),
        .wait_n  (wait_n),
        .src     (src),
        .romSel  (romSel),
        .vidBank (vidBank),
        .mapped  (mapped)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle;
        mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
    endtask

    task automatic do_reset;
        bus_idle();
        a = 16'h0000; d = 8'h00; sdrAck = 1'b0; ce = 1'b1; divEn = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic io_write(input logic [15:0] ia, input logic [7:0] id, input logic ice);
        a = ia; d = id; iorq = 1'b0; wr = 1'b0; ce = ice;
        tick();
        bus_idle();
        ce = 1'b1;
        tick();
    endtask

    // One memory access. src/mapped are checked before the sampling edge,
    // the handshake after it; any request raised is acknowledged.
    task automatic mem_cycle(input logic [15:0] ia, input logic [7:0] id,
                             input logic isWr, input logic isRfsh, input logic isFetch,
                             input logic expReq, input logic [23:0] expA,
                             input logic [1:0] expSrc, input logic expMap,
                             input string nm);
        a = ia; d = id; mreq = 1'b0;
        rd = isWr; wr = !isWr; m1 = !isFetch; rfsh = !isRfsh;
        #1;
        chk({nm, ".src"}, 32'(src), 32'(expSrc));
        chk({nm, ".mapped"}, 32'(mapped), 32'(expMap));
        tick();
        chk({nm, ".req"}, 32'(sdrReq), 32'(expReq));
        if (expReq) begin
            chk({nm, ".addr"}, 32'(sdrA), 32'(expA));
            chk({nm, ".we"}, 32'(sdrWe), 32'(isWr));
            chk({nm, ".wait"}, 32'(wait_n), 32'd0);
        end
        if (sdrReq) begin
            tick(); tick();
            if (expReq) begin
                chk({nm, ".hold_req"}, 32'(sdrReq), 32'd1);
                chk({nm, ".hold_wait"}, 32'(wait_n), 32'd0);
            end
            sdrAck = 1'b1;
            tick();
            sdrAck = 1'b0;
            chk({nm, ".done_req"}, 32'(sdrReq), 32'd0);
            chk({nm, ".done_wait"}, 32'(wait_n), 32'd1);
        end
        bus_idle();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h4000, 8'h00, 1'b0, 1'b0, 1'b1, 24'h014000, 2'd0};
        tbl[1] = '{16'h8001, 8'h00, 1'b0, 1'b0, 1'b1, 24'h008001, 2'd0};
        tbl[2] = '{16'hC123, 8'h00, 1'b0, 1'b0, 1'b1, 24'h00C123, 2'd0};
        tbl[3] = '{16'hFFFF, 8'hAA, 1'b1, 1'b0, 1'b1, 24'h00FFFF, 2'd0};
        tbl[4] = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1};
        tbl[5] = '{16'h1234, 8'h55, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd1};
        tbl[6] = '{16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0};
        tbl[7] = '{16'h7FFF, 8'h11, 1'b1, 1'b0, 1'b1, 24'h017FFF, 2'd0};

        // Reset state
        do_reset();
        chk("rst.sdrReq",  32'(sdrReq),  32'd0);
        chk("rst.sdrWe",   32'(sdrWe),   32'd0);
        chk("rst.sdrA",    32'(sdrA),    32'd0);
        chk("rst.wait_n",  32'(wait_n),  32'd1);
        chk("rst.src",     32'(src),     32'd1);
        chk("rst.romSel",  32'(romSel),  32'd0);
        chk("rst.vidBank", 32'(vidBank), 32'd0);
        chk("rst.mapped",  32'(mapped),  32'd0);

        // 7FFD paging and lock
        io_write(16'h7FFD, 8'h27, 1'b1);
        chk("lock.romSel", 32'(romSel), 32'd0);
        mem_cycle(16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h01C000, 2'd0, 1'b0, "lock.rdC000");
        io_write(16'h7FFD, 8'h00, 1'b1);
        io_write(16'h7FFD, 8'h18, 1'b1);
        chk("lock.romSel2", 32'(romSel), 32'd0);
        chk("lock.vid2", 32'(vidBank), 32'd0);
        mem_cycle(16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h01C000, 2'd0, 1'b0, "lock.rdC000b");

        // ce gating, then table-driven decode with ramBank=3
        do_reset();
        io_write(16'h7FFD, 8'h08, 1'b0);
        chk("ce0.vid", 32'(vidBank), 32'd0);
        io_write(16'h7FFD, 8'h03, 1'b1);
        for (int i = 0; i < 8; i++) begin
            mem_cycle(tbl[i].a, tbl[i].d, tbl[i].isWr, tbl[i].isRfsh, 1'b0,
                      tbl[i].expReq, tbl[i].expA, tbl[i].expSrc, 1'b0,
                      $sformatf("vec%0d", i));
        end
        io_write(16'h7FFD, 8'h08, 1'b1);
        chk("vid.set", 32'(vidBank), 32'd1);

        // Automap entry / exit
        do_reset();
        mem_cycle(16'h0038, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "am.f0038");
        mem_cycle(16'h0039, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd2, 1'b1, "am.f0039");
        mem_cycle(16'h1FF9, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd2, 1'b1, "am.f1FF9");
        mem_cycle(16'h0100, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "am.f0100");
        divEn = 1'b0;
        mem_cycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "am.dis0000");
        mem_cycle(16'h0001, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "am.dis0001");
        divEn = 1'b1;

        // 3Dxx trap with ROM 3, then E3 mapram / read-only page 3
        do_reset();
        io_write(16'h1FFD, 8'h04, 1'b1);
        io_write(16'h7FFD, 8'h10, 1'b1);
        chk("trap.romSel", 32'(romSel), 32'd3);
        mem_cycle(16'h3D2F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 24'h041D2F, 2'd0, 1'b1, "trap.f3D2F");
        io_write(16'h00E3, 8'h43, 1'b1);
        mem_cycle(16'h2000, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 2'd0, 1'b1, "e3.wr2000");
        mem_cycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h046000, 2'd0, 1'b1, "e3.rd0000");
        mem_cycle(16'h2005, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h046005, 2'd0, 1'b1, "e3.rd2005");

        // No trap without ROM 3
        do_reset();
        mem_cycle(16'h3D2F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "notrap.f3D2F");
        mem_cycle(16'h3D30, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "notrap.f3D30");

        // +3 special all-RAM mode, cfg=3
        do_reset();
        io_write(16'h1FFD, 8'h07, 1'b1);
        chk("sp.romSel", 32'(romSel), 32'd2);
        mem_cycle(16'h4000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h01C000, 2'd0, 1'b0, "sp.rd4000");
        mem_cycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h010000, 2'd0, 1'b0, "sp.rd0000");
        mem_cycle(16'h8000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h018000, 2'd0, 1'b0, "sp.rd8000");
        mem_cycle(16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00C000, 2'd0, 1'b0, "sp.rdC000");

        // Reset in the middle of a request
        do_reset();
        io_write(16'h7FFD, 8'h27, 1'b1);
        mem_cycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "mid.f0000");
        chk("mid.armed", 32'(mapped), 32'd1);
        a = 16'hC000; mreq = 1'b0; rd = 1'b0;
        tick();
        chk("mid.req", 32'(sdrReq), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid.rst_req",  32'(sdrReq), 32'd0);
        chk("mid.rst_wait", 32'(wait_n), 32'd1);
        bus_idle();
        tick();
        reset = 1'b0;
        tick();
        chk("mid.mapped", 32'(mapped), 32'd0);
        io_write(16'h7FFD, 8'h10, 1'b1);
        chk("mid.unlocked", 32'(romSel), 32'd1);
        mem_cycle(16'h0039, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 2'd1, 1'b0, "mid.f0039");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
